uart_rx_fsm: RTL
================

# uart_rx_fsm

Receive-side controller for the UART-to-APB bridge. It consumes the serial line after the two-flop bit synchronizer, which idles high. It detects start bits, times each bit with a programmable oversampling prescaler, and majority-votes three samples around each bit centre. It assembles LSB-first data, checks optional parity and the stop bit, and hands one byte per frame to the frame/APB command decoder.

## Interface
- DATA_WIDTH, 8, number of data bits per frame
- PRESCALE_WIDTH, 6, width of the oversampling ratio input
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- rx_in  in  1  synchronized serial line, idle high
- prescale  in  PRESCALE_WIDTH  clocks per bit (P); legal range 4..2^PRESCALE_WIDTH-1; sampled at frame start
- par_en  in  1  1 = frame carries a parity bit; sampled at frame start
- par_typ  in  1  0 = even, 1 = odd; sampled at frame start
- data_out  out  DATA_WIDTH  last received data word
- data_valid  out  1  one-cycle pulse: clean frame received
- par_err  out  1  one-cycle pulse: parity mismatch
- stp_err  out  1  one-cycle pulse: stop bit sampled low
- busy  out  1  high while a frame is in progress

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE behaviour:
  - The frame begins in the cycle (t0) where IDLE sees rx_in=0.
  - At t0: latch prescale, par_en and par_typ; set edge_cnt to 1, bit_cnt to 0; go to START.
- Counters:
  - edge_cnt counts 0..P-1 and wraps to 0 at each bit boundary. In cycle t0+n, edge_cnt = n mod P.
  - Let H = floor(P/2). Sample rx_in at edge_cnt = H-1, H and H+1.
  - The registered decision is the 2-of-3 majority, available after edge_cnt = H+1.
- START: a majority of 1 is a glitch. Return to IDLE at the next edge; no outputs pulse. Otherwise go to DATA at the edge_cnt = P-1 wrap.
- DATA:
  - Shift each decision into bit position bit_cnt (LSB first).
  - After DATA_WIDTH bits, at the wrap, go to PARITY if par_en=1, else STOP.
- PARITY:
  - Expected parity bit = XOR(data) for even, ~XOR(data) for odd.
  - A mismatch sets an internal error flag. Go to STOP at the wrap.
- STOP:
  - At the decision point, go straight to IDLE; the remaining half stop bit is not waited out, which allows back-to-back frames.
  - On that same transition:
    - data_out is updated with the received word, even on error.
    - stp_err pulses if the stop decision is 0.
    - par_err pulses if the parity flag is set.
    - data_valid pulses only if neither error occurred.
    - par_err and stp_err may pulse together.
- Width and counting rules:
  - edge_cnt is PRESCALE_WIDTH bits.
  - bit_cnt is clog2(DATA_WIDTH+1) bits.
  - No counter overflows for any legal P.
- Changes to prescale, par_en or par_typ after t0 have no effect until the next frame.

## Timing
- Reset values (all outputs):
  - data_out = 0, data_valid = 0, par_err = 0, stp_err = 0, busy = 0.
  - State = IDLE; all counters and the shift register = 0.
- Reset mid-frame: the frame is discarded immediately with no pulses. The first start bit is accepted after rst deasserts.
- busy is high from t0+1 up to and including the cycle before the result pulses; it is low in the cycle the pulses are high.
- Result latency:
  - Let S = index of the stop bit: 1+DATA_WIDTH, plus 1 if par_en.
  - data_valid, par_err and stp_err are high exactly in cycle t0 + S·P + H + 2, for one clock.
  - Example, P=8, 8N1: S=9, H=4, pulse in cycle t0+78.
- A low on rx_in in IDLE in the pulse cycle or any later cycle starts a new frame. No dead time is required beyond the IDLE cycle.
- Glitch rejection: a low pulse shorter than H-1 cycles never yields a false start.

## Test plan
- 8N1 frame, P=8, byte 0xA5: line low at t0 -> data_out=0xA5 and data_valid=1 only in cycle t0+78; par_err=0, stp_err=0; busy low from t0+78.
- par_en=1, even parity, P=16, byte 0x3C:
  - Parity bit 0 -> data_valid=1, data_out=0x3C.
  - Repeat with parity bit 1 -> par_err=1, data_valid=0, data_out=0x3C.
- 8N1 frame, P=8, byte 0x81 with stop bit driven low -> stp_err pulses, data_valid=0, data_out=0x81; the next correct frame, 0x7E, yields data_valid.
- Glitch, P=8: rx_in low for 3 cycles, then high -> FSM returns to IDLE, busy drops, no output pulses. A real frame 0x12 afterwards is received correctly.
- Back-to-back, P=8: frames 0x55 then 0xAA with 1-bit stop and no idle gap -> two data_valid pulses, data_out 0x55 then 0xAA, no errors.
- Reset mid-frame: assert rst during data bit 4 -> all outputs 0 immediately, no pulses. Release rst, send 0xC3 -> data_valid with 0xC3.

Source files
------------

// File: rtl/uart_rx_fsm_if.sv
// Bundle of the serial line, per-frame configuration and received-byte
// results exchanged between the line driver side and the receive controller.
interface uart_rx_fsm_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      rx_in;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      par_en;
    logic                      par_typ;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      data_valid;
    logic                      par_err;
    logic                      stp_err;
    logic                      busy;

    modport master (
        output rx_in, prescale, par_en, par_typ,
        input  data_out, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  rx_in, prescale, par_en, par_typ,
        output data_out, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampled UART receive controller. Detects a start bit,
// times every bit with a prescaler latched at frame start, takes a 2-of-3
// majority vote around each bit centre, assembles LSB-first data, checks
// optional parity and the stop bit, and reports one result per frame.
module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic          clk,
    input logic          rst,
    uart_rx_fsm_if.slave bus
);
    localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE    = PRESCALE_WIDTH'(1);
    localparam logic [BIT_CNT_WIDTH-1:0]  BIT_ONE     = BIT_CNT_WIDTH'(1);
    localparam logic [BIT_CNT_WIDTH-1:0]  LAST_BIT    = BIT_CNT_WIDTH'(DATA_WIDTH);
    localparam logic [BIT_CNT_WIDTH-1:0]  LAST_BIT_M1 = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      samp_a;
    logic                      samp_b;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_flag;
    logic [DATA_WIDTH-1:0]     data_out_q;
    logic                      data_valid_q;
    logic                      par_err_q;
    logic                      stp_err_q;
    logic                      busy_q;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      at_wrap;
    logic                      at_samp_a;
    logic                      at_samp_b;
    logic                      at_decide;
    logic                      vote;
    logic                      exp_parity;
    logic                      bits_done;

    assign half       = prescale_q >> 1;
    assign at_wrap    = (edge_cnt == prescale_q - EDGE_ONE);
    assign at_samp_a  = (edge_cnt == half - EDGE_ONE);
    assign at_samp_b  = (edge_cnt == half);
    assign at_decide  = (edge_cnt == half + EDGE_ONE);
    assign vote       = (samp_a & samp_b) | (samp_a & bus.rx_in) | (samp_b & bus.rx_in);
    assign exp_parity = (^shift_reg) ^ par_typ_q;
    // With the smallest prescale the last decision and the wrap share a cycle,
    // so the bit that is being counted right now must also finish the word.
    assign bits_done  = (bit_cnt == LAST_BIT) || (at_decide && (bit_cnt == LAST_BIT_M1));

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.busy       = busy_q;

    // Frame sequencing, bit timing, sampling and registered result pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            samp_a       <= 1'b0;
            samp_b       <= 1'b0;
            shift_reg    <= '0;
            par_flag     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= at_wrap ? '0 : edge_cnt + EDGE_ONE;
                if (at_samp_a) begin
                    samp_a <= bus.rx_in;
                end
                if (at_samp_b) begin
                    samp_b <= bus.rx_in;
                end
            end

            case (state)
                IDLE: begin
                    if (!bus.rx_in) begin
                        prescale_q <= bus.prescale;
                        par_en_q   <= bus.par_en;
                        par_typ_q  <= bus.par_typ;
                        edge_cnt   <= EDGE_ONE;
                        bit_cnt    <= '0;
                        par_flag   <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (at_decide && vote) begin
                        edge_cnt <= '0;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end else if (at_wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (at_decide) begin
                        shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= bit_cnt + BIT_ONE;
                    end
                    if (at_wrap && bits_done) begin
                        state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (at_decide && (vote != exp_parity)) begin
                        par_flag <= 1'b1;
                    end
                    if (at_wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (at_decide) begin
                        data_out_q   <= shift_reg;
                        stp_err_q    <= ~vote;
                        par_err_q    <= par_flag;
                        data_valid_q <= vote & ~par_flag;
                        edge_cnt     <= '0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
